audio_sample_sequencer: RTL

//   Sequences the codec sample stream through an external processing stage (filter/modulator).

---
 rtl/audio_sample_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/audio_sample_sequencer.sv
// audio_sample_sequencer
//   Moves stereo samples from the codec ADC side through an external
//   processing stage and queues the results in a small FIFO that drains
//   into the codec DAC side.
//   Optional feature macro: SEQ_BYPASS_EN (adds the 'bypass' input that lets
//   a captured sample skip the processing stage).
//   dbg_state exposes the sequencing FSM state (IDLE=0, ISSUE=1,
//   WAIT_RES=2, PUSH=3) for observation.

module audio_sample_sequencer #(
    parameter int DW           = 24,
    parameter int FIFO_DEPTH   = 4,
    parameter int PROC_TIMEOUT = 255
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    // codec ADC side
    input  logic          read_ready,
    output logic          read,
    input  logic [DW-1:0] readdata_left,
    input  logic [DW-1:0] readdata_right,
    // codec DAC side
    input  logic          write_ready,
    output logic          write,
    output logic [DW-1:0] writedata_left,
    output logic [DW-1:0] writedata_right,
    // processing stage
    output logic          proc_valid,
    input  logic          proc_ready,
    output logic [DW-1:0] proc_left,
    output logic [DW-1:0] proc_right,
    input  logic          res_valid,
    input  logic [DW-1:0] res_left,
    input  logic [DW-1:0] res_right,
    // sticky status
    output logic          timeout_err,
    output logic          underrun,
`ifdef SEQ_BYPASS_EN
    input  logic          bypass,
`endif
    output logic [1:0]    dbg_state
);

    // Handshake to the processing stage: a sample is transferred on a cycle
    // where proc_valid && proc_ready are both high; once proc_valid rises it
    // stays high with proc_left/proc_right unchanged until that transfer.
    // The result side has no back-pressure: res_valid is a single-cycle
    // strobe and is only consumed while waiting for a result.

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(PROC_TIMEOUT + 1);

    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_LAST_C = TW'(PROC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RES = 2'd2,
        S_PUSH     = 2'd3
    } state_t;

    // FSM registers
    state_t        state_q;
    logic          read_q;
    logic          proc_valid_q;
    logic [DW-1:0] proc_left_q;
    logic [DW-1:0] proc_right_q;
    logic [DW-1:0] res_left_q;
    logic [DW-1:0] res_right_q;
    logic [TW-1:0] tmo_cnt_q;
    logic          timeout_err_q;

    // FIFO registers
    logic [2*DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    // DAC side registers
    logic          write_q;
    logic [DW-1:0] writedata_left_q;
    logic [DW-1:0] writedata_right_q;
    logic          underrun_q;

    logic fifo_empty;
    logic fifo_has_space;
    logic push;
    logic pop;

    assign fifo_empty     = (count_q == '0);
    assign fifo_has_space = (count_q < DEPTH_C);
    // The FSM only enters PUSH after checking for space in IDLE, and nothing
    // else pushes, so the push never overflows.
    assign push = (state_q == S_PUSH);
    // write_q gating keeps the DAC strobe from firing on back-to-back cycles.
    assign pop  = write_ready && !fifo_empty && !write_q;

    // Sequencing FSM: capture from ADC, hand to the stage, collect result.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= S_IDLE;
            read_q        <= 1'b0;
            proc_valid_q  <= 1'b0;
            proc_left_q   <= '0;
            proc_right_q  <= '0;
            res_left_q    <= '0;
            res_right_q   <= '0;
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            read_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (read_ready && fifo_has_space) begin
                        read_q <= 1'b1;
`ifdef SEQ_BYPASS_EN
                        if (bypass) begin
                            res_left_q  <= readdata_left;
                            res_right_q <= readdata_right;
                            state_q     <= S_PUSH;
                        end else begin
                            proc_left_q  <= readdata_left;
                            proc_right_q <= readdata_right;
                            proc_valid_q <= 1'b1;
                            state_q      <= S_ISSUE;
                        end
`else
                        proc_left_q  <= readdata_left;
                        proc_right_q <= readdata_right;
                        proc_valid_q <= 1'b1;
                        state_q      <= S_ISSUE;
`endif
                    end
                end
                S_ISSUE: begin
                    if (proc_valid_q && proc_ready) begin
                        proc_valid_q <= 1'b0;
                        tmo_cnt_q    <= '0;
                        state_q      <= S_WAIT_RES;
                    end
                end
                S_WAIT_RES: begin
                    if (res_valid) begin
                        res_left_q  <= res_left;
                        res_right_q <= res_right;
                        state_q     <= S_PUSH;
                    end else if (tmo_cnt_q == TO_LAST_C) begin
                        // Stage never answered: queue silence so the DAC
                        // stream keeps its cadence.
                        res_left_q    <= '0;
                        res_right_q   <= '0;
                        timeout_err_q <= 1'b1;
                        state_q       <= S_PUSH;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                S_PUSH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {res_left_q, res_right_q};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count alone.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // DAC side: pop the head into registered write data, flag underruns.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            write_q           <= 1'b0;
            writedata_left_q  <= '0;
            writedata_right_q <= '0;
            underrun_q        <= 1'b0;
        end else begin
            write_q <= pop;
            if (pop) begin
                {writedata_left_q, writedata_right_q} <= mem_q[rd_ptr_q];
            end
            if (write_ready && fifo_empty) begin
                underrun_q <= 1'b1;
            end
        end
    end

    assign read            = read_q;
    assign proc_valid      = proc_valid_q;
    assign proc_left       = proc_left_q;
    assign proc_right      = proc_right_q;
    assign timeout_err     = timeout_err_q;
    assign write           = write_q;
    assign writedata_left  = writedata_left_q;
    assign writedata_right = writedata_right_q;
    assign underrun        = underrun_q;
    assign dbg_state       = state_q;

endmodule
